// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//
// Pipeline control unit for the in-order 5-stage core (IF, ID, EXE, MEM, WB).
// It sits beside the stage registers and makes four decisions every cycle:
//   - RAW hazard detection at ID against a small scoreboard of in-flight
//     register writes. A hazard holds PC and IF_ID and bubbles ID_EXE.
//   - Wrong-path squash when EXE resolves a taken branch.
//   - Clean HALT sequencing. Fetch stops, the pipe drains, then halt is raised.
//   - A saturating count of hazard-stall cycles.
//
// Handshake semantics: there is no valid/ready pair on this block. id_valid
// qualifies every id_* field in the same cycle. The instruction in ID is
// consumed (issued) on a rising edge when id_valid=1, no hazard, no taken
// branch, and state=RUN. Otherwise it stays in ID and is either held
// (stall_if=1) or squashed (flush_if_id=1).
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   id_valid            ID holds a real instruction
//   id_rs1/_en          source 1 address / source 1 is read
//   id_rs2/_en          source 2 address / source 2 is read
//   id_rd/_en           destination address / instruction writes id_rd
//   id_halt             ID instruction is HALT
//   exe_br_taken        EXE resolved a taken branch this cycle
//   stall_if            hold PC and IF_ID
//   bubble_exe          load a NOP into ID_EXE
//   flush_if_id         squash IF_ID contents
//   flush_id_exe        squash ID_EXE input
//   fetch_en            IF may fetch
//   halt                pipeline drained, core halted (registered)
//   state               0 = RUN, 1 = DRAIN, 2 = HALTED (FSM debug view)
//   stall_cnt           saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int REG_ADDR_LEN = 5,
   parameter int WB_DEPTH     = 3,
   parameter int ZERO_REG     = 1,
   parameter int CNT_W        = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    id_valid,
   input  logic [REG_ADDR_LEN-1:0] id_rs1,
   input  logic                    id_rs1_en,
   input  logic [REG_ADDR_LEN-1:0] id_rs2,
   input  logic                    id_rs2_en,
   input  logic [REG_ADDR_LEN-1:0] id_rd,
   input  logic                    id_rd_en,
   input  logic                    id_halt,
   input  logic                    exe_br_taken,
   output logic                    stall_if,
   output logic                    bubble_exe,
   output logic                    flush_if_id,
   output logic                    flush_id_exe,
   output logic                    fetch_en,
   output logic                    halt,
   output logic [1:0]              state,
   output logic [CNT_W-1:0]        stall_cnt
);

   localparam int DCNT_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [DCNT_W-1:0]       r_drain_cnt;
   logic [DCNT_W-1:0]       w_drain_cnt_nxt;
   logic                    r_drain_first;
   logic                    w_drain_first_nxt;
   logic                    r_halt;
   logic [CNT_W-1:0]        r_stall_cnt;

   // Scoreboard: entry 0 is the instruction now in EXE, the last entry is in WB.
   logic [WB_DEPTH-1:0]     r_sb_vld;
   logic [REG_ADDR_LEN-1:0] r_sb_addr [WB_DEPTH];

   // ---------------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------------
   logic w_hit_rs1;
   logic w_hit_rs2;
   logic w_rs1_live;
   logic w_rs2_live;
   logic w_hz;
   logic w_issue;
   logic w_sb_load;

   // The WB entry is deliberately not searched. The register file is written
   // in the first half of the cycle, so ID already reads the new value.
   always_comb begin
      w_hit_rs1 = 1'b0;
      w_hit_rs2 = 1'b0;
      for (int i = 0; i < WB_DEPTH - 1; i++) begin
         if (r_sb_vld[i] && (r_sb_addr[i] == id_rs1)) w_hit_rs1 = 1'b1;
         if (r_sb_vld[i] && (r_sb_addr[i] == id_rs2)) w_hit_rs2 = 1'b1;
      end
   end

   // With a hardwired zero register, reading x0 can never depend on anything.
   assign w_rs1_live = id_rs1_en & ~((ZERO_REG != 0) && (id_rs1 == '0));
   assign w_rs2_live = id_rs2_en & ~((ZERO_REG != 0) && (id_rs2 == '0));

   assign w_hz    = id_valid & ((w_rs1_live & w_hit_rs1) | (w_rs2_live & w_hit_rs2));
   assign w_issue = id_valid & ~w_hz & ~exe_br_taken & (r_state == ST_RUN);

   // HALT travels down the pipe as a non-writer regardless of id_rd_en.
   assign w_sb_load = w_issue & id_rd_en & ~id_halt;

   // ---------------------------------------------------------------------------
   // Scoreboard shift register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sb_vld <= '0;
         for (int i = 0; i < WB_DEPTH; i++) r_sb_addr[i] <= '0;
      end else begin
         r_sb_vld[0]  <= w_sb_load;
         r_sb_addr[0] <= id_rd;
         for (int i = 1; i < WB_DEPTH; i++) begin
            r_sb_vld[i]  <= r_sb_vld[i-1];
            r_sb_addr[i] <= r_sb_addr[i-1];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_RUN;
         r_drain_cnt   <= '0;
         r_drain_first <= 1'b0;
         r_halt        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_drain_cnt   <= w_drain_cnt_nxt;
         r_drain_first <= w_drain_first_nxt;
         r_halt        <= (w_state_nxt == ST_HALTED);
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and control outputs
   // ---------------------------------------------------------------------------
   logic w_stall_if;
   logic w_bubble_exe;
   logic w_flush_if_id;
   logic w_flush_id_exe;
   logic w_fetch_en;

   always_comb begin
      w_state_nxt       = r_state;
      w_drain_cnt_nxt   = r_drain_cnt;
      w_drain_first_nxt = 1'b0;
      w_stall_if        = 1'b0;
      w_bubble_exe      = 1'b0;
      w_flush_if_id     = 1'b0;
      w_flush_id_exe    = 1'b0;
      w_fetch_en        = 1'b1;

      case (r_state)
         ST_RUN: begin
            // A taken branch outranks a stall: the stalled instruction is
            // on the wrong path, so it is squashed rather than held.
            w_stall_if     = w_hz & ~exe_br_taken;
            w_bubble_exe   = w_hz | exe_br_taken;
            w_flush_if_id  = exe_br_taken;
            w_flush_id_exe = exe_br_taken;
            if (w_issue && id_halt) begin
               w_state_nxt       = ST_DRAIN;
               w_drain_cnt_nxt   = DCNT_W'(WB_DEPTH - 1);
               w_drain_first_nxt = 1'b1;
            end
         end

         ST_DRAIN: begin
            // Whatever was fetched behind HALT is squashed; nothing issues.
            w_fetch_en    = 1'b0;
            w_flush_if_id = 1'b1;
            w_bubble_exe  = 1'b1;
            if (r_drain_first && exe_br_taken) begin
               // The HALT itself was wrong-path: resume at the branch target.
               w_state_nxt    = ST_RUN;
               w_fetch_en     = 1'b1;
               w_flush_id_exe = 1'b1;
            end else if (r_drain_cnt == '0) begin
               w_state_nxt = ST_HALTED;
            end else begin
               w_drain_cnt_nxt = r_drain_cnt - DCNT_W'(1);
            end
         end

         ST_HALTED: begin
            // Only rst leaves this state.
            w_fetch_en    = 1'b0;
            w_flush_if_id = 1'b1;
            w_bubble_exe  = 1'b1;
         end

         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Saturating stall counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall_if && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign stall_if     = w_stall_if;
   assign bubble_exe   = w_bubble_exe;
   assign flush_if_id  = w_flush_if_id;
   assign flush_id_exe = w_flush_id_exe;
   assign fetch_en     = w_fetch_en;
   assign halt         = r_halt;
   assign state        = r_state;
   assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//
// Directed bench for pipe_ctrl, built with a 4-bit stall counter so that
// saturation can be reached quickly. Each stimulus step drives the ID/EXE
// inputs, then pushes the hand-computed expected output vector for that
// cycle, along with a mask, into a queue. A monitor samples the DUT on the
// falling edge and pops one entry per cycle. Steps whose mask is zero are
// stimulus only.
//
// Expected vector layout:
//   {stall_if, bubble_exe, flush_if_id, flush_id_exe, fetch_en, halt,
//    state[1:0], stall_cnt[3:0]}
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

   localparam int RW = 5;
   localparam int CW = 4;
   localparam int EW = 12;

   localparam logic [EW-1:0] M_ALL   = '1;
   localparam logic [EW-1:0] M_NONE  = '0;
   localparam logic [EW-1:0] M_STATE = 12'b0000_0011_0000;
   // Everything except fetch_en.
   localparam logic [EW-1:0] M_NOFE  = 12'b1111_0111_1111;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          id_valid;
   logic [RW-1:0] id_rs1;
   logic          id_rs1_en;
   logic [RW-1:0] id_rs2;
   logic          id_rs2_en;
   logic [RW-1:0] id_rd;
   logic          id_rd_en;
   logic          id_halt;
   logic          exe_br_taken;
   logic          stall_if;
   logic          bubble_exe;
   logic          flush_if_id;
   logic          flush_id_exe;
   logic          fetch_en;
   logic          halt;
   logic [1:0]    state;
   logic [CW-1:0] stall_cnt;

   pipe_ctrl #(
      .REG_ADDR_LEN (RW),
      .WB_DEPTH     (3),
      .ZERO_REG     (1),
      .CNT_W        (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs1_en    (id_rs1_en),
      .id_rs2       (id_rs2),
      .id_rs2_en    (id_rs2_en),
      .id_rd        (id_rd),
      .id_rd_en     (id_rd_en),
      .id_halt      (id_halt),
      .exe_br_taken (exe_br_taken),
      .stall_if     (stall_if),
      .bubble_exe   (bubble_exe),
      .flush_if_id  (flush_if_id),
      .flush_id_exe (flush_id_exe),
      .fetch_en     (fetch_en),
      .halt         (halt),
      .state        (state),
      .stall_cnt    (stall_cnt)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] msk_q[$];
   string         nm_q[$];
   int            n_chk  = 0;
   int            n_fail = 0;

   logic [EW-1:0] act;
   assign act = {stall_if, bubble_exe, flush_if_id, flush_id_exe, fetch_en,
                 halt, state, stall_cnt};

   always @(negedge clk) begin
      logic [EW-1:0] w_exp;
      logic [EW-1:0] w_msk;
      string         w_nm;
      if (exp_q.size() > 0) begin
         w_exp = exp_q.pop_front();
         w_msk = msk_q.pop_front();
         w_nm  = nm_q.pop_front();
         if (w_msk != '0) begin
            n_chk++;
            if ((act & w_msk) !== (w_exp & w_msk)) begin
               n_fail++;
               $display("FAIL %s: got %b required %b (mask %b) at %0t",
                        w_nm, act, w_exp, w_msk, $time);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   function automatic logic [EW-1:0] ev(input logic s, input logic b,
                                        input logic fi, input logic fe,
                                        input logic fen, input logic h,
                                        input logic [1:0] st,
                                        input logic [CW-1:0] c);
      return {s, b, fi, fe, fen, h, st, c};
   endfunction

   // Quiet RUN cycle with a given counter value.
   function automatic logic [EW-1:0] ev_run(input logic [CW-1:0] c);
      return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, c);
   endfunction

   task automatic set_in(input logic v,
                         input logic [RW-1:0] rs1, input logic rs1e,
                         input logic [RW-1:0] rs2, input logic rs2e,
                         input logic [RW-1:0] rd,  input logic rde,
                         input logic hlt, input logic br);
      id_valid     = v;
      id_rs1       = rs1;
      id_rs1_en    = rs1e;
      id_rs2       = rs2;
      id_rs2_en    = rs2e;
      id_rd        = rd;
      id_rd_en     = rde;
      id_halt      = hlt;
      exe_br_taken = br;
   endtask

   task automatic set_idle();
      set_in(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   // Push the expectation for the current cycle, then advance one cycle.
   task automatic step(input logic [EW-1:0] e, input logic [EW-1:0] m,
                       input string nm);
      exp_q.push_back(e);
      msk_q.push_back(m);
      nm_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      rst = 1'b1;
      set_idle();
      @(posedge clk);
      #1;
      step('0, M_NONE, "rst0");
      step('0, M_NONE, "rst1");
      rst = 1'b0;
      step(ev_run(0), M_ALL, "reset_state");

      // RAW through rs1: two stall cycles, then issue.
      set_in(1, 0, 0, 0, 0, 3, 1, 0, 0);  step(ev_run(0), M_ALL, "raw_producer");
      set_in(1, 3, 1, 0, 0, 4, 1, 0, 0);  step(ev(1,1,0,0,1,0,2'd0,0), M_ALL, "raw_stall1");
      step(ev(1,1,0,0,1,0,2'd0,1), M_ALL, "raw_stall2");
      step(ev_run(2), M_ALL, "raw_issue");
      set_idle();                         step(ev_run(2), M_ALL, "raw_cnt2");

      // Register 0 never creates a dependency.
      set_in(1, 0, 0, 0, 0, 0, 1, 0, 0);  step(ev_run(2), M_ALL, "zero_producer");
      set_in(1, 0, 1, 0, 0, 5, 1, 0, 0);  step(ev_run(2), M_ALL, "zero_no_stall");
      set_idle();                         step(ev_run(2), M_ALL, "zero_idle");

      // RAW through rs2.
      set_in(1, 0, 0, 0, 0, 7, 1, 0, 0);  step(ev_run(2), M_ALL, "rs2_producer");
      set_in(1, 0, 0, 7, 1, 0, 0, 0, 0);  step(ev(1,1,0,0,1,0,2'd0,2), M_ALL, "rs2_stall1");
      step(ev(1,1,0,0,1,0,2'd0,3), M_ALL, "rs2_stall2");
      step(ev_run(4), M_ALL, "rs2_issue");

      // Dependent instruction in ID together with a taken branch.
      set_in(1, 0, 0, 0, 0, 9, 1, 0, 0);  step(ev_run(4), M_ALL, "br_producer");
      set_in(1, 9, 1, 0, 0, 0, 0, 0, 1);  step(ev(0,1,1,1,1,0,2'd0,4), M_ALL, "br_over_stall");
      set_idle();                         step(ev_run(4), M_ALL, "br_cnt_kept");
      step(ev_run(4), M_ALL, "br_idle");

      // Clean HALT: three DRAIN cycles, then HALTED for good.
      set_in(1, 0, 0, 0, 0, 0, 0, 1, 0);  step(ev_run(4), M_ALL, "halt_issue");
      set_idle();
      for (int k = 0; k < 3; k++)
         step(ev(0,1,1,0,0,0,2'd1,4), M_ALL, "drain");
      for (int k = 0; k < 10; k++) begin
         // Instructions presented while halted must change nothing.
         if (k % 2 == 0) set_in(1, 0, 0, 0, 0, 6, 1, 0, 0);
         else            set_idle();
         step(ev(0,1,1,0,0,1,2'd2,4), M_ALL, "halted");
      end

      set_idle();
      rst = 1'b1;
      step('0, M_NONE, "rst2");
      step('0, M_NONE, "rst3");
      rst = 1'b0;
      step(ev_run(0), M_ALL, "reset_from_halted");

      // HALT squashed by a branch in the first DRAIN cycle.
      set_in(1, 0, 0, 0, 0, 0, 0, 1, 0);  step(ev_run(0), M_ALL, "hb_halt_issue");
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);  step(ev(0,1,1,1,0,0,2'd1,0), M_NOFE, "hb_branch");
      set_idle();                         step(ev_run(0), M_ALL, "hb_back_to_run");
      step(ev_run(0), M_ALL, "hb_run2");

      // Branch together with HALT: no DRAIN.
      set_in(1, 0, 0, 0, 0, 0, 0, 1, 1);  step(ev(0,1,1,1,1,0,2'd0,0), M_ALL, "bh_same_cycle");
      set_idle();                         step(ev_run(0), M_ALL, "bh_stay_run");

      // Hazard together with HALT: HALT waits, then drains; reset mid-drain.
      set_in(1, 0, 0, 0, 0, 10, 1, 0, 0); step(ev_run(0), M_ALL, "hh_producer");
      set_in(1, 10, 1, 0, 0, 0, 0, 1, 0); step(ev(1,1,0,0,1,0,2'd0,0), M_ALL, "hh_wait1");
      step(ev(1,1,0,0,1,0,2'd0,1), M_ALL, "hh_wait2");
      step(ev_run(2), M_ALL, "hh_issue");
      set_idle();
      rst = 1'b1;                         step(ev(0,0,0,0,0,0,2'd1,0), M_STATE, "hh_in_drain");
      rst = 1'b0;                         step(ev_run(0), M_ALL, "rst_in_drain");

      // Saturation: self-dependent instruction held in ID for 40 cycles
      // gives 26 stall cycles, well beyond 15.
      set_in(1, 3, 1, 0, 0, 3, 1, 0, 0);
      for (int k = 0; k < 40; k++) step('0, M_NONE, "sat_drive");
      set_idle();
      step(ev_run(15), M_ALL, "sat_15");
      set_in(1, 3, 1, 0, 0, 0, 0, 0, 0);
      step(ev(1,1,0,0,1,0,2'd0,15), M_ALL, "sat_stall_more");
      set_idle();
      step(ev_run(15), M_ALL, "sat_hold");

      @(negedge clk);
      #1;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_queue: got %0d pending required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline control unit for the in-order 5-stage core (IF, ID, EXE, MEM, WB). Sits beside the stage registers.
- Tracks in-flight register writes in a scoreboard shift register and detects RAW hazards at ID. It stalls IF/ID and inserts bubbles into ID_EXE.
- Squashes wrong-path instructions on a taken branch from EXE.
- Sequences a clean HALT: stops fetch, drains the pipe, then asserts halt.
- Keeps a saturating stall-cycle counter.

Parameters:
- REG_ADDR_LEN, 5: register address width.
- WB_DEPTH, 3: number of cycles from leaving ID to register write (EXE, MEM, WB); also the scoreboard depth.
- ZERO_REG, 1: 1 means register 0 is hardwired and never causes a hazard.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_ADDR_LEN  source 1 address.
- id_rs1_en  in  1  source 1 is read.
- id_rs2  in  REG_ADDR_LEN  source 2 address.
- id_rs2_en  in  1  source 2 is read.
- id_rd  in  REG_ADDR_LEN  destination address.
- id_rd_en  in  1  instruction writes id_rd.
- id_halt  in  1  ID instruction is HALT.
- exe_br_taken  in  1  EXE resolved a taken branch this cycle.
- stall_if  out  1  hold PC and IF_ID.
- bubble_exe  out  1  load a NOP into ID_EXE.
- flush_if_id  out  1  squash IF_ID contents.
- flush_id_exe  out  1  squash ID_EXE input.
- fetch_en  out  1  IF may fetch.
- halt  out  1  pipeline drained, core halted.
- state  out  2  0 = RUN, 1 = DRAIN, 2 = HALTED.
- stall_cnt  out  CNT_W  number of hazard-stall cycles.

Behaviour:
- **Reset** (rst=1 at posedge): all scoreboard entries invalid; state=RUN; halt=0; stall_cnt=0. The reset value of every combinational output follows from this state:
  - fetch_en=1
  - stall_if=0
  - bubble_exe=0
  - flush_if_id=0
  - flush_id_exe=0
  - Reset mid-drain or in HALTED returns to RUN the following cycle.
- **Scoreboard:** WB_DEPTH entries, each {valid, addr}. Entry 0 is the instruction now in EXE; the last entry is in WB.
  - Every cycle the entries shift by one and the last entry retires.
  - Entry 0 loads {id_valid & id_rd_en & issue, id_rd}. Otherwise it loads invalid (bubble).
- **Hazard (combinational, same cycle):**
  - hz = id_valid and, for either source with enable set, the address equals a valid entry's address, for any entry except the last.
  - The last entry is excluded because WB writes to the register file before the ID read in the same cycle.
  - When ZERO_REG=1, address 0 never matches.
- **Issue:** issue = id_valid & ~hz & ~exe_br_taken & (state==RUN).
- **Outputs in RUN:**
  - stall_if = hz & ~exe_br_taken.
  - bubble_exe = hz | exe_br_taken.
  - flush_if_id = flush_id_exe = exe_br_taken. A branch has priority over a stall: the stalled instruction is wrong-path.
- **stall_cnt:** +1 per cycle with stall_if=1; saturates at all-ones without wrapping.
- **FSM transitions:**
  - RUN to DRAIN: id_halt & issue. The HALT occupies entry 0 as a non-writer.
  - DRAIN: fetch_en=0 and flush_if_id=1 while the internal drain counter runs WB_DEPTH cycles. The counter starts at WB_DEPTH-1 on entry and reaches HALTED after it hits 0.
  - DRAIN: if exe_br_taken arrives in the first DRAIN cycle, the HALT was wrong-path. State returns to RUN, fetch_en=1, and normal flush applies.
  - HALTED: halt=1 (registered), fetch_en=0, and scoreboard entry 0 receives only bubbles. HALTED is left only by rst.
- **Simultaneous events:**
  - exe_br_taken together with id_halt: the HALT is not issued and no DRAIN entry occurs.
  - hz together with id_halt: the HALT waits until the hazard clears.

Test Plan:
- rst=1 for 2 cycles, then idle. Required: halt=0, state=0, fetch_en=1, stall_cnt=0, and all stall/flush outputs 0.
- Issue rd=3. Next cycle issue rs1=3. Required: stall_if=1 and bubble_exe=1 for exactly 2 cycles, then issue; stall_cnt=2. The same test with rs1=0 and rd=0 must give no stall.
- Dependent instruction in ID while exe_br_taken=1. Required: flush_if_id=1, flush_id_exe=1, stall_if=0, and stall_cnt unchanged.
- HALT issued with no hazard. Required: state=1 for 3 cycles with fetch_en=0, then state=2 and halt=1 held for 10 more cycles.
- HALT issued, then exe_br_taken=1 on the next cycle. Required: state returns to 0, fetch_en=1, halt stays 0.
- Force 2^CNT_W+5 stall cycles (CNT_W=4 build). Required: stall_cnt stays at 15. Assert rst while in DRAIN: state=0 on the next cycle.
